// File: rtl/module_keypad_emulator.sv
// Behavioural 4x4 keypad: answers the reader's column scan on the row lines,
// scripting each requested key press with optional contact bounce on make and break.
//
// state | meaning
// IDLE  | contact open, ready for a key request
// BIN   | bounce on press, contact follows lfsr[0]
// HOLD  | contact firmly closed
// BOUT  | bounce on release, contact follows lfsr[0]
// GAP   | contact open; last cycle signals completion
module module_keypad_emulator #(
  parameter int HOLD_CYCLES   = 2700000,
  parameter int BOUNCE_CYCLES = 135000,
  parameter int GAP_CYCLES    = 1350000,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] col,
  output logic [3:0] fil,
  input  logic       req_valid,
  input  logic [3:0] req_key,
  output logic       req_ready,
  output logic       key_down,
  output logic       done,
  output logic [7:0] press_cnt
);

  localparam int MAX_HB = (HOLD_CYCLES > BOUNCE_CYCLES) ? HOLD_CYCLES : BOUNCE_CYCLES;
  localparam int MAX_ALL = (MAX_HB > GAP_CYCLES) ? MAX_HB : GAP_CYCLES;
  localparam int CW = (MAX_ALL < 1) ? 1 : $clog2(MAX_ALL + 1);

  // Phase timers are down-counters loaded with length-1; zero marks the last cycle.
  localparam logic [CW-1:0] BOUNCE_LAST = CW'(BOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_BIN, S_HOLD, S_BOUT, S_GAP
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [7:0]      lfsr;
  logic [3:0]      key;
  logic [7:0]      press_cnt_q;
  logic            accept;
  logic            contact;
  logic            bouncing;
  logic            lfsr_fb;

  assign req_ready = (state == S_IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign bouncing  = (state == S_BIN) || (state == S_BOUT);
  assign contact   = (state == S_HOLD) || (bouncing && lfsr[0]);
  assign key_down  = contact;
  assign done      = (state == S_GAP) && (cnt == '0);
  assign press_cnt = press_cnt_q;
  assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (BOUNCE_CYCLES == 0) begin
            state_nx = S_HOLD;
            cnt_nx   = HOLD_LAST;
          end else begin
            state_nx = S_BIN;
            cnt_nx   = BOUNCE_LAST;
          end
        end
      end
      S_BIN: begin
        if (cnt == '0) begin
          state_nx = S_HOLD;
          cnt_nx   = HOLD_LAST;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt == '0) begin
          if (BOUNCE_CYCLES == 0) begin
            state_nx = S_GAP;
            cnt_nx   = GAP_LAST;
          end else begin
            state_nx = S_BOUT;
            cnt_nx   = BOUNCE_LAST;
          end
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      S_BOUT: begin
        if (cnt == '0) begin
          state_nx = S_GAP;
          cnt_nx   = GAP_LAST;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      S_GAP: begin
        if (cnt == '0) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Only the addressed column can pull the latched key's row low.
  always_comb begin
    fil = 4'b1111;
    if (contact && !col[key[1:0]]) fil[key[3:2]] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      lfsr        <= LFSR_SEED;
      key         <= 4'h0;
      press_cnt_q <= 8'h00;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) key <= req_key;
      if (bouncing) lfsr <= {lfsr[6:0], lfsr_fb};
      if (done) press_cnt_q <= press_cnt_q + 8'h01;
    end
  end

endmodule

// File: tb/tb_module_keypad_emulator.sv
// Directed bench for module_keypad_emulator with short phases (HOLD 8, BOUNCE 4, GAP 3);
// expected bounce bits are hand-derived from seed A5 (taps 8,6,5,4).
module tb_module_keypad_emulator;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] col;
  logic [3:0] fil;
  logic       req_valid;
  logic [3:0] req_key;
  logic       req_ready;
  logic       key_down;
  logic       done;
  logic [7:0] press_cnt;

  int n_pass  = 0;
  int n_total = 0;

  // key_down per cycle after accept (1..20): BIN 1010, HOLD x8, BOUT 0111, GAP 000, IDLE 0
  int kd_tab [1:20] = '{1,0,1,0, 1,1,1,1,1,1,1,1, 0,1,1,1, 0,0,0, 0};

  module_keypad_emulator #(
    .HOLD_CYCLES(8), .BOUNCE_CYCLES(4), .GAP_CYCLES(3), .LFSR_SEED(8'hA5)
  ) dut (
    .clk(clk), .reset(reset), .col(col), .fil(fil),
    .req_valid(req_valid), .req_key(req_key), .req_ready(req_ready),
    .key_down(key_down), .done(done), .press_cnt(press_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    logic [3:0] scan [4];
    scan[0] = 4'b1110; scan[1] = 4'b1101; scan[2] = 4'b1011; scan[3] = 4'b0111;

    reset = 1'b1; col = 4'b1111; req_valid = 1'b0; req_key = 4'h0;
    tick; tick;
    check("ready_in_reset", req_ready, 1'b0);
    reset = 1'b0;
    #1;
    check("ready_after_reset", req_ready, 1'b1);
    check("press_cnt_reset", press_cnt, 8'd0);
    check("key_down_reset", key_down, 1'b0);
    check("done_reset", done, 1'b0);
    for (int i = 0; i < 4; i++) begin
      col = scan[i];
      #1;
      check("fil_idle_scan", fil, 4'b1111);
    end

    // key 6 = row 1, column 2; column 2 driven low
    col = 4'b1011; req_key = 4'h6; req_valid = 1'b1;
    #1;
    check("ready_before_accept", req_ready, 1'b1);
    tick;
    req_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      check("key_down_seq1", key_down, kd_tab[k][0]);
      check("fil_seq1", fil, kd_tab[k][0] ? 4'b1101 : 4'b1111);
      check("done_seq1", done, k == 19);
      check("ready_seq1", req_ready, k == 20);
      if (k < 20) tick;
    end
    check("press_cnt_seq1", press_cnt, 8'd1);

    // wrong column low: rows stay idle, contact still closes in HOLD
    col = 4'b1110; req_valid = 1'b1;
    tick;
    req_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      check("fil_wrong_col", fil, 4'b1111);
      if (k >= 5 && k <= 12) check("key_down_hold2", key_down, 1'b1);
      check("done_seq2", done, k == 19);
      if (k < 20) tick;
    end
    check("press_cnt_seq2", press_cnt, 8'd2);

    // req_valid held high with changing key: only one accept per IDLE
    col = 4'b1011; req_key = 4'h6; req_valid = 1'b1;
    tick;
    for (int k = 1; k <= 19; k++) begin
      req_key = (k % 2 == 1) ? 4'h9 : 4'hA;
      #1;
      check("ready_busy", req_ready, 1'b0);
      if (k >= 5 && k <= 12) check("fil_latched_key", fil, 4'b1101);
      tick;
    end
    check("ready_seq3_end", req_ready, 1'b1);
    check("press_cnt_seq3", press_cnt, 8'd3);
    req_key = 4'h9;
    tick;
    req_valid = 1'b0;
    #1;
    check("ready_after_reaccept", req_ready, 1'b0);

    // key 9 = row 2, column 1; reset while in HOLD
    col = 4'b1101;
    tick; tick; tick; tick;
    check("fil_hold_key9", fil, 4'b1011);
    check("key_down_hold_key9", key_down, 1'b1);
    reset = 1'b1;
    tick;
    check("fil_after_reset", fil, 4'b1111);
    check("key_down_after_reset", key_down, 1'b0);
    check("press_cnt_after_reset", press_cnt, 8'd0);
    check("ready_during_reset", req_ready, 1'b0);
    reset = 1'b0;
    begin
      int seen_done = 0;
      for (int k = 0; k < 25; k++) begin
        if (done) seen_done++;
        tick;
      end
      check("no_done_after_reset", seen_done[7:0], 8'd0);
    end
    check("ready_idle_post_reset", req_ready, 1'b1);

    // 256 completed sequences wrap press_cnt
    col = 4'b1111; req_key = 4'h0; req_valid = 1'b1;
    for (int n = 1; n <= 256; n++) begin
      for (int c = 0; c < 40 && !done; c++) tick;
      if (!done) begin
        check("done_wait", done, 1'b1);
        break;
      end
      tick;
      if (n == 255) check("press_cnt_255", press_cnt, 8'd255);
      if (n == 256) check("press_cnt_wrap", press_cnt, 8'd0);
    end
    req_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
